cpu_regfile: RTL

CPU_REGFILE -- requirements
Module: cpu_regfile

---
 rtl/cpu_regfile.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cpu_regfile.sv
// Register file with two registered read ports, one write port with
// same-cycle forwarding, and a sequential one-register-per-cycle clear.
module cpu_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write_en,
    input  logic [ADDR_W-1:0]        write_addr,
    input  logic [DATA_W-1:0]        write_data,
    input  logic                     clr,
    input  logic                     rd_en_a,
    input  logic [ADDR_W-1:0]        rd_addr_a,
    input  logic                     rd_en_b,
    input  logic [ADDR_W-1:0]        rd_addr_b,
    output logic [DATA_W-1:0]        rd_data_a,
    output logic [DATA_W-1:0]        rd_data_b,
    output logic                     wr_ack,
    output logic                     wr_drop,
    output logic                     busy,
    output logic [(2**ADDR_W)-1:0]   written
);

    localparam int N = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   cnt_r;
    logic [ADDR_W-1:0]   cnt_s;
    logic [DATA_W-1:0]   regs_r [N];
    logic                wr_accept_s;
    logic                wr_reject_s;
    logic [DATA_W-1:0]   rd_next_a_s;
    logic [DATA_W-1:0]   rd_next_b_s;

    // Next-state and clear-counter logic; clr is ignored once CLEAR is running.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (clr) begin
                    state_s = CLEAR;
                    cnt_s   = '0;
                end else begin
                    state_s = IDLE;
                    cnt_s   = cnt_r;
                end
            end
            CLEAR: begin
                cnt_s = cnt_r + ADDR_W'(1);
                if (cnt_r == LAST_ADDR) begin
                    state_s = IDLE;
                end else begin
                    state_s = CLEAR;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Write arbitration: a clear request or a running clear rejects the write.
    always_comb begin
        wr_accept_s = 1'b0;
        wr_reject_s = 1'b0;
        if (write_en) begin
            if ((state_r == IDLE) && !clr) begin
                wr_accept_s = 1'b1;
            end else begin
                wr_reject_s = 1'b1;
            end
        end else begin
            wr_accept_s = 1'b0;
            wr_reject_s = 1'b0;
        end
    end

    // Read-port source selection with write-to-read forwarding.
    always_comb begin
        rd_next_a_s = regs_r[rd_addr_a];
        rd_next_b_s = regs_r[rd_addr_b];
        if (state_r == CLEAR) begin
            rd_next_a_s = '0;
            rd_next_b_s = '0;
        end else begin
            if (wr_accept_s && (write_addr == rd_addr_a)) begin
                rd_next_a_s = write_data;
            end else begin
                rd_next_a_s = regs_r[rd_addr_a];
            end
            if (wr_accept_s && (write_addr == rd_addr_b)) begin
                rd_next_b_s = write_data;
            end else begin
                rd_next_b_s = regs_r[rd_addr_b];
            end
        end
    end

    // State register, clear counter and busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy    <= (state_s == CLEAR);
        end
    end

    // Register array and written flags; clearing and writing never overlap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                regs_r[i] <= '0;
            end
            written <= '0;
        end else if (state_r == CLEAR) begin
            regs_r[cnt_r]  <= '0;
            written[cnt_r] <= 1'b0;
        end else if (wr_accept_s) begin
            regs_r[write_addr]  <= write_data;
            written[write_addr] <= 1'b1;
        end
    end

    // Registered read data and write handshake pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
            wr_ack    <= 1'b0;
            wr_drop   <= 1'b0;
        end else begin
            if (rd_en_a) begin
                rd_data_a <= rd_next_a_s;
            end
            if (rd_en_b) begin
                rd_data_b <= rd_next_b_s;
            end
            wr_ack  <= wr_accept_s;
            wr_drop <= wr_reject_s;
        end
    end

endmodule
